// File: rtl/a5_wb_ctrl.sv
`default_nettype none
// ==== a5_wb_ctrl : Wishbone register block with per-channel keystream FIFOs for NUM_CH A5/1 generators ====
// ==== Revision 1.0 ====
module a5_wb_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic                   irq_o,
  output logic [NUM_CH-1:0]      gen_load_o,
  output logic [64*NUM_CH-1:0]   gen_key_o,
  output logic [22*NUM_CH-1:0]   gen_frame_o,
  input  logic [NUM_CH-1:0]      gen_valid_i,
  input  logic [32*NUM_CH-1:0]   gen_data_i,
  output logic [NUM_CH-1:0]      gen_ready_o
);
  localparam int          PW   = $clog2(FIFO_DEPTH);
  localparam int          LW   = PW + 1;
  localparam logic [31:0] C_ID = 32'h4135_4132;

  logic                    r_ack;
  logic [31:0]             r_dat;
  logic [NUM_CH-1:0]       r_irq_st;
  logic [NUM_CH-1:0]       r_irq_en;
  logic                    w_access;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_glob;
  logic [2:0]              w_win;
  logic [4:0]              w_off;
  logic [31:0]             w_rdata;
  logic [NUM_CH-1:0]       w_ch_hit;
  logic [NUM_CH-1:0]       w_irq_set;
  logic [NUM_CH-1:0]       w_irq_clr;
  logic [NUM_CH-1:0][31:0] w_ch_rd;
  logic                    w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return v;
  endfunction

  assign w_access  = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr      = w_access & wbs_we_i;
  assign w_rd      = w_access & ~wbs_we_i;
  assign w_win     = wbs_adr_i[7:5];
  assign w_off     = wbs_adr_i[4:0];
  assign w_glob    = (w_win == 3'd0);
  assign w_unused  = &{1'b0, wbs_adr_i[31:8]};
  assign w_irq_clr = (w_wr && w_glob && w_off == 5'h04 && wbs_sel_i[0]) ? wbs_dat_i[NUM_CH-1:0] : '0;

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = |(r_irq_st & r_irq_en);

  always_comb begin
    w_rdata = '0;
    if (w_glob) begin
      case (w_off)
        5'h00:   w_rdata = C_ID;
        5'h04:   w_rdata = 32'(r_irq_st);
        5'h08:   w_rdata = 32'(r_irq_en);
        default: w_rdata = '0;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_hit[c]) w_rdata = w_ch_rd[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq_st <= '0;
      r_irq_en <= '0;
    end else begin
      r_ack    <= w_access;
      r_dat    <= w_rd ? w_rdata : 32'h0;
      // A same-cycle FIFO-full event overrides the software clear.
      r_irq_st <= (r_irq_st & ~w_irq_clr) | w_irq_set;
      if (w_wr && w_glob && w_off == 5'h08 && wbs_sel_i[0]) r_irq_en <= wbs_dat_i[NUM_CH-1:0];
    end
  end

  for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [LW-1:0] r_lvl;
    logic          r_unf;
    logic          r_auto;
    logic          r_load;
    logic [31:0]   r_klo;
    logic [31:0]   r_khi;
    logic [21:0]   r_frame;
    logic [63:0]   r_gkey;
    logic [21:0]   r_gframe;
    logic          w_cwr;
    logic          w_ctl;
    logic          w_load;
    logic          w_clear;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_data_rd;
    logic          w_pop;
    logic [31:0]   w_frame_m;

    assign w_ch_hit[gc] = (w_win == 3'(gc + 1));
    assign w_cwr        = w_wr & w_ch_hit[gc];
    assign w_ctl        = w_cwr & (w_off == 5'h04) & wbs_sel_i[0];
    assign w_load       = w_ctl & wbs_dat_i[0];
    assign w_clear      = w_ctl & (wbs_dat_i[0] | wbs_dat_i[1]);
    assign w_full       = (r_lvl == LW'(FIFO_DEPTH));
    assign w_empty      = (r_lvl == '0);
    assign w_push       = gen_valid_i[gc] & ~w_full;
    assign w_data_rd    = w_rd & w_ch_hit[gc] & (w_off == 5'h08);
    assign w_pop        = w_data_rd & ~w_empty;
    assign w_frame_m    = f_merge({10'b0, r_frame}, wbs_dat_i, wbs_sel_i);
    assign w_irq_set[gc] = ~w_clear & w_push & ~w_pop & (r_lvl == LW'(FIFO_DEPTH - 1));

    assign gen_ready_o[gc]              = ~w_full;
    assign gen_load_o[gc]               = r_load;
    assign gen_key_o[64*gc +: 64]       = r_gkey;
    assign gen_frame_o[22*gc +: 22]     = r_gframe;

    always_comb begin
      w_ch_rd[gc] = '0;
      case (w_off)
        5'h00:   w_ch_rd[gc] = {19'b0, 5'(r_lvl), 5'b0, r_unf, w_full, ~w_empty};
        5'h04:   w_ch_rd[gc] = {29'b0, r_auto, 2'b0};
        5'h08:   w_ch_rd[gc] = w_empty ? 32'h0 : r_mem[r_rp];
        5'h0C:   w_ch_rd[gc] = r_klo;
        5'h10:   w_ch_rd[gc] = r_khi;
        5'h14:   w_ch_rd[gc] = {10'b0, r_frame};
        default: w_ch_rd[gc] = '0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        r_wp     <= '0;
        r_rp     <= '0;
        r_lvl    <= '0;
        r_unf    <= 1'b0;
        r_auto   <= 1'b0;
        r_load   <= 1'b0;
        r_klo    <= '0;
        r_khi    <= '0;
        r_frame  <= '0;
        r_gkey   <= '0;
        r_gframe <= '0;
      end else begin
        r_load <= w_load;
        if (w_load) begin
          r_gkey   <= {r_khi, r_klo};
          r_gframe <= r_frame;
        end
        if (w_ctl) r_auto <= wbs_dat_i[2];

        // AUTOINC from the same write applies to this load.
        if (w_load && wbs_dat_i[2])            r_frame <= r_frame + 22'd1;
        else if (w_cwr && w_off == 5'h14)      r_frame <= w_frame_m[21:0];
        if (w_cwr && w_off == 5'h0C)           r_klo   <= f_merge(r_klo, wbs_dat_i, wbs_sel_i);
        if (w_cwr && w_off == 5'h10)           r_khi   <= f_merge(r_khi, wbs_dat_i, wbs_sel_i);

        if (w_data_rd && w_empty)              r_unf <= 1'b1;
        else if (w_cwr && w_off == 5'h00 && wbs_sel_i[0] && wbs_dat_i[2]) r_unf <= 1'b0;

        if (w_clear) begin
          r_wp  <= '0;
          r_rp  <= '0;
          r_lvl <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wp] <= gen_data_i[32*gc +: 32];
            r_wp        <= r_wp + PW'(1);
          end
          if (w_pop) r_rp <= r_rp + PW'(1);
          if (w_push && !w_pop)      r_lvl <= r_lvl + LW'(1);
          else if (!w_push && w_pop) r_lvl <= r_lvl - LW'(1);
        end
      end
    end
  end : g_ch
endmodule
`default_nettype wire

// File: doc/a5_wb_ctrl.md
A5_WB_CTRL -- requirements
Module: a5_wb_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of A5/1 generator channels (legal 1..6).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, keystream words buffered per channel (power of two, 2..16).
REQ-003 SHALL have ports:
- clk  in  1  single clock.
- reset_n  in  1  reset, synchronous and active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write.
- wbs_sel_i  in  4  byte lane select.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- irq_o  out  1  interrupt, level.
- gen_load_o  out  NUM_CH  per-channel load pulse to generator.
- gen_key_o  out  64*NUM_CH  key, channel c at [64c+63:64c].
- gen_frame_o  out  22*NUM_CH  frame, channel c at [22c+21:22c].
- gen_valid_i  in  NUM_CH  generator keystream word valid.
- gen_data_i  in  32*NUM_CH  keystream word, channel c at [32c+31:32c].
- gen_ready_o  out  NUM_CH  FIFO can accept a word.

Function
REQ-004 access = stb & cyc & ~ack; ack SHALL rise the cycle after access and fall the next cycle; every access is acked, mapped or not.
REQ-005 Decode SHALL use wbs_adr_i[7:0]; upper bits ignored.
REQ-006 Read data SHALL be registered with ack; unmapped reads return 0; wbs_dat_o = 0 when not acking.
REQ-007 Writes SHALL update only the bytes whose wbs_sel_i bit is set; unmapped writes are ignored.
REQ-008 Global map: 0x00 ID RO 0x41354132; 0x04 IRQ_STATUS [NUM_CH-1:0] W1C; 0x08 IRQ_EN [NUM_CH-1:0] RW.
REQ-009 Channel c window base = 0x20*(c+1): +0x00 STATUS RO, +0x04 CONTROL, +0x08 DATA RO, +0x0C KEY_LO RW, +0x10 KEY_HI RW, +0x14 FRAME RW [21:0].
REQ-010 STATUS: bit0 not-empty, bit1 full, bit2 underflow (sticky; W1C via STATUS bit2), bits[12:8] level 0..FIFO_DEPTH.
REQ-011 CONTROL write, sel[0] set: bit0 load strobe, bit1 flush strobe, bit2 AUTOINC (stored). CONTROL reads {29'b0, AUTOINC, 2'b0}.
REQ-012 Load strobe SHALL pulse gen_load_o[c] high for exactly one cycle, the cycle after the write is accepted, with the current key and frame.
REQ-013 With AUTOINC set, FRAME SHALL increment by 1 mod 2^22 in the same cycle gen_load_o[c] pulses; the pulse carries the pre-increment value.
REQ-014 A load or flush SHALL empty channel c's FIFO (level 0) in the cycle the strobe is accepted; a push in that cycle is discarded.
REQ-015 gen_ready_o[c] = ~full; a push occurs when gen_valid_i[c] & gen_ready_o[c].
REQ-016 DATA read while non-empty SHALL return the oldest word and pop it at the ack edge.
REQ-017 DATA read while empty SHALL return 0, not pop, and set underflow.
REQ-018 Simultaneous push and pop SHALL leave the level unchanged; FIFO order is strict FIFO with pointer wrap at FIFO_DEPTH.
REQ-019 IRQ_STATUS[c] SHALL set on the cycle a push makes the level equal to FIFO_DEPTH; set wins over a same-cycle W1C clear.
REQ-020 irq_o = |(IRQ_STATUS & IRQ_EN).
REQ-021 Channels SHALL be independent; an access to one channel SHALL not alter another.

Reset
REQ-022 When reset_n is low at a clk edge, the block SHALL clear all registers, FIFOs, flags, AUTOINC and IRQ state to 0.
REQ-023 During reset: ack=0, dat_o=0, irq_o=0, gen_load_o=0, gen_key_o=0, gen_frame_o=0, gen_ready_o=all 1 on the first edge after reset is released.
REQ-024 Reset asserted mid-transaction SHALL abort it; no ack follows.

Verification
REQ-025 Read 0x00 -> ack one cycle later, dat_o=0x41354132; next cycle ack=0, dat_o=0.
REQ-026 Write ch0 KEY_LO=0x11223344 with sel=4'b0011 after reset -> readback 0x00003344.
REQ-027 ch1 FRAME=0x3FFFFF, CONTROL=0x5 -> gen_load_o[1] one-cycle pulse with frame 0x3FFFFF; FRAME readback 0x000000.
REQ-028 Push 0xA,0xB,0xC,0xD into ch0 (DEPTH 4) -> STATUS level=4, full=1, gen_ready_o[0]=0, IRQ_STATUS[0]=1, irq_o=1 only when IRQ_EN[0]=1; DATA reads return A,B,C,D in order.
REQ-029 DATA read on empty ch0 -> returns 0, STATUS bit2=1; write STATUS 0x4 -> bit2=0.
REQ-030 Push on gen_valid_i[0] in the same cycle as a flush write -> level=0 afterwards, word lost.
